// File: rtl/cv32e40s_lockstep_ctrl.sv
// Lockstep controller: delays master outputs to align with the lagging checker core,
// compares them and sequences checker resets and retries, escalating to a sticky FAIL.
module cv32e40s_lockstep_ctrl #(
  parameter int N          = 32,
  parameter int DELAY      = 2,
  parameter int RST_CYCLES = 4,
  parameter int MAX_RETRY  = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         enable_i,
  input  logic         clear_i,
  input  logic         valid_i,
  input  logic [N-1:0] core_master_i,
  input  logic [N-1:0] core_checker_i,
  output logic         mismatch_o,
  output logic         core_reset_req_o,
  output logic         fail_o,
  output logic [2:0]   state_o,
  output logic [7:0]   err_cnt_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SYNC    = 3'd1,
    RUN     = 3'd2,
    RECOVER = 3'd3,
    FAIL    = 3'd4
  } state_e;

  state_e               state_q, state_n;
  logic [7:0]           cnt_q, cnt_n;
  logic [3:0]           retry_q, retry_n;
  logic [7:0]           err_n;
  logic                 mm, flush;
  logic [DELAY:1]       vld_pipe;
  logic [DELAY:1][N-1:0] dat_pipe;
  logic                 d_valid;
  logic [N-1:0]         d_master;

  assign flush    = (state_q == IDLE && enable_i) || (state_q == RECOVER);
  assign d_valid  = vld_pipe[DELAY];
  assign d_master = dat_pipe[DELAY];
  assign state_o  = state_q;

  // Only the valid bits carry meaning; data stages are free-running.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= valid_i;
      for (int i = 2; i <= DELAY; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    dat_pipe[1] <= core_master_i;
    for (int i = 2; i <= DELAY; i++) dat_pipe[i] <= dat_pipe[i-1];
  end

  // Valid disagreement alone is a mismatch; data only matters when both sides are valid.
  always_comb begin
    mm = 1'b0;
    if (state_q == RUN && (d_valid || valid_i))
      mm = (d_valid != valid_i) || (d_master != core_checker_i);
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    retry_n = retry_q;
    err_n   = err_cnt_o;
    case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_n = SYNC;
          cnt_n   = 8'(DELAY);
        end
      end
      SYNC: begin
        if (!enable_i)         state_n = IDLE;
        else if (cnt_q <= 8'd1) state_n = RUN;
        else                   cnt_n   = cnt_q - 8'd1;
      end
      RUN: begin
        if (mm) begin
          if (retry_q < 4'(MAX_RETRY)) begin
            state_n = RECOVER;
            cnt_n   = 8'(RST_CYCLES);
            retry_n = retry_q + 4'd1;
          end else begin
            state_n = FAIL;
          end
        end else if (!enable_i) begin
          state_n = IDLE;
        end
      end
      RECOVER: begin
        if (cnt_q <= 8'd1) begin
          state_n = SYNC;
          cnt_n   = 8'(DELAY);
        end else begin
          cnt_n = cnt_q - 8'd1;
        end
      end
      FAIL: begin
        if (clear_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (mm && err_cnt_o != 8'hFF) err_n = err_cnt_o + 8'd1;
    if (clear_i) begin
      retry_n = '0;
      err_n   = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      retry_q          <= '0;
      err_cnt_o        <= '0;
      mismatch_o       <= 1'b0;
      core_reset_req_o <= 1'b0;
      fail_o           <= 1'b0;
    end else begin
      state_q          <= state_n;
      cnt_q            <= cnt_n;
      retry_q          <= retry_n;
      err_cnt_o        <= err_n;
      mismatch_o       <= mm;
      core_reset_req_o <= (state_n == RECOVER) || (state_n == FAIL);
      fail_o           <= (state_n == FAIL);
    end
  end

endmodule

// File: tb/tb_cv32e40s_lockstep_ctrl.sv
// Directed bench for cv32e40s_lockstep_ctrl: checker stream is the master stream lagged by 2.
module tb_cv32e40s_lockstep_ctrl;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst_i, enable_i, clear_i, valid_i;
  logic [N-1:0] core_master_i, core_checker_i;
  logic         mismatch_o, core_reset_req_o, fail_o;
  logic [2:0]   state_o;
  logic [7:0]   err_cnt_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  cv32e40s_lockstep_ctrl #(.N(N), .DELAY(2), .RST_CYCLES(4), .MAX_RETRY(3)) dut (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .clear_i(clear_i), .valid_i(valid_i),
    .core_master_i(core_master_i), .core_checker_i(core_checker_i),
    .mismatch_o(mismatch_o), .core_reset_req_o(core_reset_req_o), .fail_o(fail_o),
    .state_o(state_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mval(input int c);
    return (32'(c) * 32'h9E3779B1) ^ 32'h5A5A_1234;
  endfunction

  // Drive one cycle of streams (checker lags 2, optional bit flips), then sample 1ns after the edge.
  task automatic tick(input logic [N-1:0] flip);
    core_master_i  = mval(cyc);
    core_checker_i = mval(cyc - 2) ^ flip;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input int st, input int mm, input int rr, input int fl, input int ec);
    chk({tag, "_state"}, 32'(state_o), 32'(st));
    chk({tag, "_mm"},    32'(mismatch_o), 32'(mm));
    chk({tag, "_rreq"},  32'(core_reset_req_o), 32'(rr));
    chk({tag, "_fail"},  32'(fail_o), 32'(fl));
    chk({tag, "_err"},   32'(err_cnt_o), 32'(ec));
  endtask

  // From the tick after a mismatch entry: 3 more RECOVER cycles, 2 SYNC, then RUN.
  task automatic ride_recovery(input string tag, input int ec);
    repeat (3) tick('0);
    outs({tag, "_rec"}, 3, 0, 1, 0, ec);
    tick('0);
    outs({tag, "_sync0"}, 1, 0, 0, 0, ec);
    tick('0);
    chk({tag, "_sync1"}, 32'(state_o), 32'd1);
    tick('0);
    outs({tag, "_run"}, 2, 0, 0, 0, ec);
  endtask

  initial begin
    rst_i = 1'b1; enable_i = 1'b0; clear_i = 1'b0; valid_i = 1'b0;
    core_master_i = '0; core_checker_i = '0;
    tick('0); tick('0);
    outs("reset", 0, 0, 0, 0, 0);
    rst_i = 1'b0;
    tick('0);
    outs("idle", 0, 0, 0, 0, 0);

    // Identical streams: IDLE -> SYNC for 2 cycles -> RUN, no mismatches
    valid_i = 1'b1; enable_i = 1'b1;
    tick('0); chk("sync_a", 32'(state_o), 32'd1);
    tick('0); chk("sync_b", 32'(state_o), 32'd1);
    tick('0); outs("run", 2, 0, 0, 0, 0);
    for (int i = 0; i < 100; i++) begin
      tick('0);
      chk("run_clean_mm", 32'(mismatch_o), 32'd0);
    end
    outs("run_end", 2, 0, 0, 0, 0);

    // Single bit-31 flip: one mismatch pulse, 4 cycles of reset request, then resync
    tick(32'h8000_0000);
    outs("inj1", 3, 1, 1, 0, 1);
    tick('0);
    outs("inj1_pulse_end", 3, 0, 1, 0, 1);
    repeat (2) tick('0);
    outs("inj1_rec4", 3, 0, 1, 0, 1);
    tick('0);
    outs("inj1_sync", 1, 0, 0, 0, 1);
    tick('0);
    tick('0);
    outs("inj1_rerun", 2, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      tick('0);
      chk("rerun_mm", 32'(mismatch_o), 32'd0);
    end

    // Clear in RUN without a mismatch zeros counters and keeps running
    clear_i = 1'b1; tick('0); clear_i = 1'b0;
    outs("clr_run", 2, 0, 0, 0, 0);

    // Three recoveries allowed, the fourth mismatch escalates to FAIL
    for (int p = 0; p < 3; p++) begin
      tick(32'(1) << p);
      outs("retry_inj", 3, 1, 1, 0, p + 1);
      ride_recovery("retry", p + 1);
      repeat (3) tick('0);
      chk("retry_quiet_mm", 32'(mismatch_o), 32'd0);
    end
    tick(32'h0000_0100);
    outs("fail_entry", 4, 1, 1, 1, 4);
    for (int i = 0; i < 6; i++) begin
      enable_i = i[0];
      valid_i  = ~i[1];
      tick(32'hFFFF_FFFF);
      outs("fail_hold", 4, 0, 1, 1, 4);
    end
    clear_i = 1'b1; enable_i = 1'b0; valid_i = 1'b1;
    tick('0);
    clear_i = 1'b0;
    outs("fail_clr", 0, 0, 0, 0, 0);
    tick('0);
    outs("fail_clr_idle", 0, 0, 0, 0, 0);

    // Valid drop with equal data is still a mismatch
    enable_i = 1'b1;
    repeat (3) tick('0);
    outs("vd_run", 2, 0, 0, 0, 0);
    repeat (4) tick('0);
    valid_i = 1'b0;
    tick('0);
    valid_i = 1'b1;
    outs("vdrop", 3, 1, 1, 0, 1);

    // Reset in the 2nd RECOVER cycle overrides everything
    tick('0);
    outs("rec2", 3, 0, 1, 0, 1);
    rst_i = 1'b1;
    tick('0);
    rst_i = 1'b0; enable_i = 1'b0;
    outs("rst_rec", 0, 0, 0, 0, 0);
    tick('0);
    outs("rst_rec_idle", 0, 0, 0, 0, 0);

    // Mismatch with enable low and clear in the same cycle: RECOVER wins, count is 0
    enable_i = 1'b1;
    repeat (3) tick('0);
    chk("mdc_run", 32'(state_o), 32'd2);
    repeat (3) tick('0);
    enable_i = 1'b0; clear_i = 1'b1;
    tick(32'h0000_0020);
    enable_i = 1'b1; clear_i = 1'b0;
    outs("mm_dis_clr", 3, 1, 1, 0, 0);
    ride_recovery("mdc", 0);
    tick(32'h0001_0000);
    outs("mdc_next", 3, 1, 1, 0, 1);
    ride_recovery("mdc2", 1);

    // Disable in RUN without a mismatch returns to IDLE
    enable_i = 1'b0;
    tick('0);
    outs("run_disable", 0, 0, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cv32e40s_lockstep_ctrl.md
CV32E40S_LOCKSTEP_CTRL -- requirements
Module: cv32e40s_lockstep_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 32, giving the width of the concatenated core output vector (N >= 1).
REQ-002 The block SHALL have parameter DELAY, default 2, giving the checker lag in cycles behind the master (1..8).
REQ-003 The block SHALL have parameter RST_CYCLES, default 4, giving the checker-core reset request length in cycles (1..255).
REQ-004 The block SHALL have parameter MAX_RETRY, default 3, giving the number of recoveries allowed before FAIL (0..15).
REQ-005 The block SHALL have one clock; reset is synchronous and active-high.
REQ-006 The block SHALL have these ports:
 clk_i  in  1  clock, rising edge
 rst_i  in  1  synchronous active-high reset
 enable_i  in  1  lockstep checking enabled
 clear_i  in  1  clears FAIL, retry and error counters
 valid_i  in  1  core output vectors are valid this cycle
 core_master_i  in  N  master core output vector
 core_checker_i  in  N  checker core output vector, DELAY cycles late
 mismatch_o  out  1  one-cycle pulse per detected mismatch
 core_reset_req_o  out  1  reset request to checker core
 fail_o  out  1  sticky lockstep failure
 state_o  out  3  FSM state: IDLE=0, SYNC=1, RUN=2, RECOVER=3, FAIL=4
 err_cnt_o  out  8  saturating mismatch count

Function
REQ-007 A DELAY-stage shift register SHALL carry {valid_i, core_master_i} every cycle; stage DELAY output is the aligned reference (d_valid, d_master).
REQ-008 A flush SHALL clear all stage valid bits in the cycle it is applied; data bits are don't-care.
REQ-009 A compare event SHALL occur only in RUN when d_valid or valid_i is 1.
REQ-010 A compare event SHALL be a mismatch if d_valid != valid_i, or if both are 1 and any bit 0..N-1 of d_master differs from core_checker_i.
REQ-011 mismatch_o SHALL be registered, high exactly in the cycle after the mismatching compare.
REQ-012 IDLE SHALL move to SYNC when enable_i=1, applying a flush; otherwise it remains in IDLE.
REQ-013 SYNC SHALL load a cycle counter with DELAY and move to RUN after DELAY cycles, with no compares; enable_i=0 SHALL return to IDLE.
REQ-014 In RUN, a mismatch SHALL move to RECOVER if retry_cnt < MAX_RETRY, incrementing retry_cnt; otherwise it SHALL move to FAIL.
REQ-015 In RUN, enable_i=0 without a mismatch SHALL move to IDLE; a mismatch in the same cycle SHALL take precedence.
REQ-016 RECOVER SHALL assert core_reset_req_o for exactly RST_CYCLES cycles and hold the flush; it SHALL then enter SYNC regardless of enable_i.
REQ-017 FAIL SHALL drive fail_o=1 and core_reset_req_o=1 continuously; enable_i and valid_i are ignored.
REQ-018 Only clear_i (or rst_i) SHALL leave FAIL, moving to IDLE.
REQ-019 clear_i in any state SHALL zero retry_cnt and err_cnt_o next cycle; if applied in a mismatch cycle, clear wins and the count is 0; the FSM transition still occurs.
REQ-020 err_cnt_o SHALL increment per mismatch and saturate at 255.
REQ-021 All outputs SHALL be registered.

Reset
REQ-022 While rst_i=1 at a rising edge, the block SHALL set state IDLE, flush the delay line, zero all counters, and drive mismatch_o=0, core_reset_req_o=0, fail_o=0, state_o=0, err_cnt_o=0.
REQ-023 rst_i SHALL override every state, including mid-RECOVER and FAIL.

Verification
REQ-024 Bench SHALL cover: enable_i=1, identical streams with checker lagging 2 cycles, 100 cycles -> state_o 0->1->2 after 2 cycles in SYNC, no mismatch_o, err_cnt_o=0.
REQ-025 Bench SHALL cover: in RUN, flip checker bit 31 once -> mismatch_o pulse 1 cycle later, err_cnt_o=1, state_o=3, core_reset_req_o high 4 cycles, then SYNC then RUN.
REQ-026 Bench SHALL cover: 4 successive injected mismatches with MAX_RETRY=3 -> three RECOVER passes, fourth enters FAIL, fail_o=1, err_cnt_o=4; enable_i toggling has no effect; clear_i -> IDLE, err_cnt_o=0.
REQ-027 Bench SHALL cover: checker drops valid_i for 1 cycle while d_valid=1 -> mismatch detected though data are equal.
REQ-028 Bench SHALL cover: rst_i asserted in 2nd RECOVER cycle -> next cycle all outputs 0, state_o=0, core_reset_req_o deasserted.
REQ-029 Bench SHALL cover: mismatch and enable_i=0 in the same cycle -> RECOVER taken; clear_i in the same cycle -> err_cnt_o=0.
